deser_align: RTL and testbench
==============================

DESER_ALIGN -- requirements
Module: deser_align

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 4..32.
REQ-002 Parameter COMMA, default 8'hBC (WIDTH bits wide): alignment/idle character.
REQ-003 Parameter LOCK_CNT, default 4: number of consecutive aligned commas required to lock; legal range 1..15.
REQ-004 Parameter MAX_GAP, default 0: maximum number of consecutive non-comma words while locked; 0 disables the check.
REQ-005 Parameter MSB_FIRST, default 1: 1 means the first received bit is data_par[WIDTH-1]; 0 means the first received bit is data_par[0].
REQ-006 clk_nf  input  1  bit-rate clock; the only clock in the block, all flops on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 in  input  1  serial data bit.
REQ-009 in_en  input  1  qualifies in; the block samples in only on cycles where in_en=1.
REQ-010 realign  input  1  synchronous request to drop lock and re-hunt.
REQ-011 data_par  output  WIDTH  last received aligned data word.
REQ-012 valid_par  output  1  one-cycle strobe marking data_par as a new data word.
REQ-013 locked  output  1  high while in the LOCKED state.
REQ-014 comma_det  output  1  one-cycle strobe on each aligned comma received while locked.
REQ-015 lock_lost  output  1  one-cycle strobe when lock is dropped by MAX_GAP or realign.

Function
REQ-016 Shift register sr (WIDTH bits) shall update only when in_en=1: nsr = MSB_FIRST ? {sr[WIDTH-2:0],in} : {in,sr[WIDTH-1:1]}.
REQ-017 Bit counter bit_cnt (0..WIDTH-1) shall increment on each in_en=1 and wrap from WIDTH-1 to 0.
REQ-018 A word boundary is an in_en=1 cycle with bit_cnt==WIDTH-1; the word at that boundary is nsr.
REQ-019 The FSM shall have three states: HUNT, SYNC, and LOCKED.
REQ-020 In HUNT, on every in_en=1 cycle where nsr==COMMA: bit_cnt<=0, comma_cnt<=1, and the next state is SYNC (or LOCKED if LOCK_CNT==1).
REQ-021 In SYNC, at a boundary word equal to COMMA: comma_cnt shall increment, and on reaching LOCK_CNT the next state is LOCKED.
REQ-022 In SYNC, at a boundary word not equal to COMMA: the next state is HUNT and comma_cnt<=0; no lock_lost is issued.
REQ-023 In LOCKED, a boundary word equal to COMMA shall produce comma_det=1, leave valid_par=0 and data_par unchanged, and clear gap_cnt.
REQ-024 In LOCKED, a boundary word not equal to COMMA shall produce data_par<=word and valid_par=1, and increment gap_cnt (saturating).
REQ-025 If MAX_GAP!=0 and a non-comma boundary word would make gap_cnt exceed MAX_GAP: the next state is HUNT, lock_lost=1, that word is not output, and valid_par=0.
REQ-026 Latency: data_par, valid_par, and comma_det shall be registered and asserted on the clock edge that ends the boundary cycle, i.e. one cycle after the last bit is sampled.
REQ-027 valid_par, comma_det, and lock_lost shall each be high for exactly one cycle per event; they shall be 0 on every cycle with in_en=0.
REQ-028 realign=1 shall force the next state to HUNT and clear comma_cnt, gap_cnt, and bit_cnt; lock_lost=1 only if the current state is LOCKED.
REQ-029 realign has priority over a simultaneous boundary: no valid_par or comma_det is issued that cycle.
REQ-030 locked shall equal (state==LOCKED), registered.
REQ-031 In HUNT and SYNC, valid_par shall remain 0 regardless of input data.

Reset
REQ-032 While reset=1, all of the following shall be 0: sr, bit_cnt, comma_cnt, gap_cnt, data_par, valid_par, locked, comma_det, and lock_lost; state shall be HUNT.
REQ-033 Assertion of reset mid-word or while LOCKED shall take effect immediately and asynchronously, with no lock_lost strobe.
REQ-034 After reset deasserts, the block shall require a full hunt and LOCK_CNT commas before issuing any valid_par.

Verification
REQ-035 Defaults; in_en=1; 3 random bits, then 4x 8'hBC, then 8'h5A, 8'hC3 -> locked rises 1 cycle after the 4th comma's last bit; valid_par pulses with 5A then C3, 8 cycles apart.
REQ-036 Defaults; 3x BC, then 8'h11 -> no lock, state returns to HUNT; a following 4x BC then locks.
REQ-037 MSB_FIRST=0, WIDTH=10, COMMA=10'h17C, LOCK_CNT=2; stream commas then 10'h2A5 LSB-first -> data_par=10'h2A5 with valid_par high.
REQ-038 MAX_GAP=2, locked; send 3 data words -> 2 valid_par pulses, then lock_lost=1 and locked=0 on the 3rd boundary.
REQ-039 Locked; toggle in_en 0/1 randomly during 8'h7E -> exactly one valid_par with data 8'h7E; all strobes 0 on in_en=0 cycles.
REQ-040 Locked; assert realign on a boundary cycle -> no valid_par, lock_lost=1, locked=0; then assert reset mid-word -> all outputs 0 with no lock_lost.

Source files
------------

// File: rtl/deser_align.sv
// Serial-to-parallel deserializer that hunts for a comma character, qualifies
// lock over LOCK_CNT aligned commas, then emits aligned data words.
module deser_align #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] COMMA     = WIDTH'(8'hBC),
  parameter int               LOCK_CNT  = 4,
  parameter int               MAX_GAP   = 0,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk_nf,
  input  logic             reset,
  input  logic             in,
  input  logic             in_en,
  input  logic             realign,
  output logic [WIDTH-1:0] data_par,
  output logic             valid_par,
  output logic             locked,
  output logic             comma_det,
  output logic             lock_lost
);

  localparam int BW    = $clog2(WIDTH);
  localparam int GAP_W = (MAX_GAP < 15) ? 4 : $clog2(MAX_GAP + 2);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d, nsr;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]         comma_cnt_q, comma_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               comma_det_q, comma_det_d;
  logic               lock_lost_q, lock_lost_d;
  logic               locked_q, locked_d;
  logic               boundary;
  logic               is_comma;

  generate
    if (MSB_FIRST) begin : g_msb
      assign nsr = {sr_q[WIDTH-2:0], in};
    end else begin : g_lsb
      assign nsr = {in, sr_q[WIDTH-1:1]};
    end
  endgenerate

  assign boundary = in_en && (bit_cnt_q == BW'(WIDTH - 1));
  assign is_comma = (nsr == COMMA);

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    comma_det_d = 1'b0;
    lock_lost_d = 1'b0;

    if (in_en) begin
      sr_d      = nsr;
      bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
    end

    // realign outranks any boundary event landing on the same cycle
    if (realign) begin
      state_d     = HUNT;
      comma_cnt_d = '0;
      gap_cnt_d   = '0;
      bit_cnt_d   = '0;
      lock_lost_d = (state_q == LOCKED);
    end else if (in_en) begin
      case (state_q)
        HUNT: begin
          // any bit position may start a comma; realign the word counter to it
          if (is_comma) begin
            bit_cnt_d   = '0;
            comma_cnt_d = 4'd1;
            state_d     = (LOCK_CNT == 1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (boundary) begin
            if (is_comma) begin
              comma_cnt_d = comma_cnt_q + 4'd1;
              if (comma_cnt_q + 4'd1 == 4'(LOCK_CNT)) begin
                state_d = LOCKED;
              end
            end else begin
              state_d     = HUNT;
              comma_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (is_comma) begin
              comma_det_d = 1'b1;
              gap_cnt_d   = '0;
            end else if (MAX_GAP != 0 && gap_cnt_q >= GAP_W'(MAX_GAP)) begin
              state_d     = HUNT;
              lock_lost_d = 1'b1;
              gap_cnt_d   = '0;
              comma_cnt_d = '0;
            end else begin
              data_d  = nsr;
              valid_d = 1'b1;
              if (gap_cnt_q != '1) begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_nf or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      gap_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      comma_det_q <= 1'b0;
      lock_lost_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      comma_det_q <= comma_det_d;
      lock_lost_q <= lock_lost_d;
      locked_q    <= locked_d;
    end
  end

  assign data_par  = data_q;
  assign valid_par = valid_q;
  assign locked    = locked_q;
  assign comma_det = comma_det_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_deser_align.sv
// Directed bench for deser_align: three configurations checked every cycle
// against a bit-stream model, plus hand-computed spot checks.
module tb_deser_align;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic in_ab, en_ab, re_ab;
  logic in_c, en_c, re_c;

  logic [7:0] def_data, gap_data;
  logic [9:0] lsb_data;
  logic def_valid, def_locked, def_cd, def_ll;
  logic gap_valid, gap_locked, gap_cd, gap_ll;
  logic lsb_valid, lsb_locked, lsb_cd, lsb_ll;

  deser_align u_def (
    .clk_nf(clk), .reset(reset), .in(in_ab), .in_en(en_ab), .realign(re_ab),
    .data_par(def_data), .valid_par(def_valid), .locked(def_locked),
    .comma_det(def_cd), .lock_lost(def_ll)
  );

  deser_align #(.MAX_GAP(2)) u_gap (
    .clk_nf(clk), .reset(reset), .in(in_ab), .in_en(en_ab), .realign(re_ab),
    .data_par(gap_data), .valid_par(gap_valid), .locked(gap_locked),
    .comma_det(gap_cd), .lock_lost(gap_ll)
  );

  deser_align #(.WIDTH(10), .COMMA(10'h17C), .LOCK_CNT(2), .MAX_GAP(0), .MSB_FIRST(1'b0)) u_lsb (
    .clk_nf(clk), .reset(reset), .in(in_c), .in_en(en_c), .realign(re_c),
    .data_par(lsb_data), .valid_par(lsb_valid), .locked(lsb_locked),
    .comma_det(lsb_cd), .lock_lost(lsb_ll)
  );

  // Model: mode 0=hunting, 1=counting commas, 2=locked
  typedef struct packed {
    int   w;
    int   comma;
    int   lock_cnt;
    int   max_gap;
    logic msb;
    int   mode;
    int   hist;
    int   pos;
    int   commas;
    int   gap;
    int   data;
    logic valid;
    logic cd;
    logic ll;
  } model_t;

  model_t mdef, mgap, mlsb;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_def_val = 0, n_gap_val = 0, n_lsb_val = 0;
  int n_def_ll = 0, n_gap_ll = 0, n_lsb_cd = 0;
  int def_val_cyc = 0;

  function automatic model_t mreset(model_t m);
    m.mode = 0; m.hist = 0; m.pos = 0; m.commas = 0; m.gap = 0; m.data = 0;
    m.valid = 1'b0; m.cd = 1'b0; m.ll = 1'b0;
    return m;
  endfunction

  function automatic model_t mk(int w, int comma, int lock_cnt, int max_gap, logic msb);
    model_t m;
    m.w = w; m.comma = comma; m.lock_cnt = lock_cnt; m.max_gap = max_gap; m.msb = msb;
    return mreset(m);
  endfunction

  function automatic model_t mstep(model_t m, logic b, logic en, logic re);
    int   mask;
    logic bnd;
    mask = (1 << m.w) - 1;
    m.valid = 1'b0; m.cd = 1'b0; m.ll = 1'b0;
    if (en) begin
      if (m.msb) m.hist = ((m.hist << 1) | int'(b)) & mask;
      else       m.hist = (m.hist >> 1) | (int'(b) << (m.w - 1));
    end
    if (re) begin
      if (m.mode == 2) m.ll = 1'b1;
      m.mode = 0; m.commas = 0; m.gap = 0; m.pos = 0;
    end else if (en) begin
      bnd = (m.pos == m.w - 1);
      m.pos = (m.pos + 1) % m.w;
      if (m.mode == 0) begin
        if (m.hist == m.comma) begin
          m.pos = 0; m.commas = 1;
          m.mode = (m.lock_cnt == 1) ? 2 : 1;
        end
      end else if (m.mode == 1) begin
        if (bnd) begin
          if (m.hist == m.comma) begin
            m.commas = m.commas + 1;
            if (m.commas == m.lock_cnt) m.mode = 2;
          end else begin
            m.mode = 0; m.commas = 0;
          end
        end
      end else if (bnd) begin
        if (m.hist == m.comma) begin
          m.cd = 1'b1; m.gap = 0;
        end else if (m.max_gap != 0 && m.gap + 1 > m.max_gap) begin
          m.mode = 0; m.ll = 1'b1; m.gap = 0; m.commas = 0;
        end else begin
          m.data = m.hist; m.valid = 1'b1; m.gap = m.gap + 1;
        end
      end
    end
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    chk("def.data",   32'(def_data),   32'(mdef.data));
    chk("def.valid",  32'(def_valid),  32'(mdef.valid));
    chk("def.locked", 32'(def_locked), 32'(mdef.mode == 2));
    chk("def.comma",  32'(def_cd),     32'(mdef.cd));
    chk("def.lost",   32'(def_ll),     32'(mdef.ll));
    chk("gap.data",   32'(gap_data),   32'(mgap.data));
    chk("gap.valid",  32'(gap_valid),  32'(mgap.valid));
    chk("gap.locked", 32'(gap_locked), 32'(mgap.mode == 2));
    chk("gap.comma",  32'(gap_cd),     32'(mgap.cd));
    chk("gap.lost",   32'(gap_ll),     32'(mgap.ll));
    chk("lsb.data",   32'(lsb_data),   32'(mlsb.data));
    chk("lsb.valid",  32'(lsb_valid),  32'(mlsb.valid));
    chk("lsb.locked", 32'(lsb_locked), 32'(mlsb.mode == 2));
    chk("lsb.comma",  32'(lsb_cd),     32'(mlsb.cd));
    chk("lsb.lost",   32'(lsb_ll),     32'(mlsb.ll));
    if (def_valid) begin
      n_def_val = n_def_val + 1;
      def_val_cyc = cyc;
      $display("txn cyc=%0d inst=def data=%h", cyc, def_data);
    end
    if (gap_valid) begin
      n_gap_val = n_gap_val + 1;
      $display("txn cyc=%0d inst=gap data=%h", cyc, gap_data);
    end
    if (lsb_valid) begin
      n_lsb_val = n_lsb_val + 1;
      $display("txn cyc=%0d inst=lsb data=%h", cyc, lsb_data);
    end
    if (def_ll) n_def_ll = n_def_ll + 1;
    if (gap_ll) n_gap_ll = n_gap_ll + 1;
    if (lsb_cd) n_lsb_cd = n_lsb_cd + 1;
  endtask

  // Called at a falling edge: drive, let the rising edge happen, compare at the next falling edge.
  task automatic tick(logic b_ab, logic e_ab, logic r_ab, logic b_c, logic e_c, logic r_c);
    in_ab = b_ab; en_ab = e_ab; re_ab = r_ab;
    in_c = b_c; en_c = e_c; re_c = r_c;
    @(posedge clk);
    cyc = cyc + 1;
    if (reset) begin
      mdef = mreset(mdef); mgap = mreset(mgap); mlsb = mreset(mlsb);
    end else begin
      mdef = mstep(mdef, b_ab, e_ab, r_ab);
      mgap = mstep(mgap, b_ab, e_ab, r_ab);
      mlsb = mstep(mlsb, b_c, e_c, r_c);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic ab_bit(logic b);
    tick(b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_ab(logic [7:0] w);
    for (int i = 7; i >= 0; i--) ab_bit(w[i]);
  endtask

  task automatic send_c(logic [9:0] w);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, w[i], 1'b1, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  logic [7:0] bc = 8'hBC;
  logic [7:0] w33 = 8'h33;
  logic [7:0] w7e = 8'h7E;
  int gaps[8] = '{1, 0, 2, 1, 0, 3, 1, 2};
  int v0, l0, c0, c1;

  initial begin
    mdef = mk(8, 'hBC, 4, 0, 1'b1);
    mgap = mk(8, 'hBC, 4, 2, 1'b1);
    mlsb = mk(10, 'h17C, 2, 0, 1'b0);
    reset = 1'b1;
    in_ab = 1'b0; en_ab = 1'b0; re_ab = 1'b0;
    in_c = 1'b0; en_c = 1'b0; re_c = 1'b0;
    @(negedge clk);
    repeat (3) idle();
    chk("rst.locked", 32'(def_locked), 32'h0);
    chk("rst.data", 32'(def_data), 32'h0);
    reset = 1'b0;

    // 3 filler bits, 4 commas, then two data words
    repeat (3) ab_bit(1'b0);
    repeat (3) send_ab(8'hBC);
    for (int i = 7; i >= 1; i--) ab_bit(bc[i]);
    chk("p1.prelock", 32'(def_locked), 32'h0);
    ab_bit(bc[0]);
    chk("p1.lockrise", 32'(def_locked), 32'h1);
    v0 = n_def_val;
    send_ab(8'h5A);
    chk("p1.word1", 32'(def_data), 32'h5A);
    chk("p1.model1", 32'(mdef.data), 32'h5A);
    c1 = def_val_cyc;
    send_ab(8'hC3);
    chk("p1.word2", 32'(def_data), 32'hC3);
    chk("p1.spacing", 32'(def_val_cyc - c1), 32'd8);
    chk("p1.nvalid", 32'(n_def_val - v0), 32'd2);

    // short comma run broken by a data word must not lock
    pulse_reset();
    repeat (3) send_ab(8'hBC);
    send_ab(8'h11);
    chk("p2.nolock", 32'(def_locked), 32'h0);
    chk("p2.modelhunt", 32'(mdef.mode), 32'd0);
    repeat (4) send_ab(8'hBC);
    chk("p2.relock", 32'(def_locked), 32'h1);

    // MAX_GAP=2 instance drops lock on the third data word
    v0 = n_gap_val; l0 = n_gap_ll;
    send_ab(8'h01);
    send_ab(8'h02);
    send_ab(8'h03);
    chk("p3.gapvalid", 32'(n_gap_val - v0), 32'd2);
    chk("p3.lostnow", 32'(gap_ll), 32'h1);
    chk("p3.nlost", 32'(n_gap_ll - l0), 32'd1);
    chk("p3.gapunlock", 32'(gap_locked), 32'h0);
    chk("p3.gapdata", 32'(gap_data), 32'h02);
    chk("p3.defdata", 32'(def_data), 32'h03);

    // in_en gaps inside a word
    v0 = n_def_val;
    for (int i = 7; i >= 0; i--) begin
      for (int k = 0; k < gaps[i]; k++) begin
        idle();
        chk("p4.strobes", 32'({def_valid, def_cd, def_ll}), 32'h0);
      end
      ab_bit(w7e[i]);
    end
    chk("p4.nvalid", 32'(n_def_val - v0), 32'd1);
    chk("p4.data", 32'(def_data), 32'h7E);

    // realign on a boundary, then asynchronous reset mid-word while locked
    v0 = n_def_val; l0 = n_def_ll;
    for (int i = 7; i >= 1; i--) ab_bit(w33[i]);
    tick(w33[0], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p5.lost", 32'(def_ll), 32'h1);
    chk("p5.unlock", 32'(def_locked), 32'h0);
    chk("p5.novalid", 32'(n_def_val - v0), 32'd0);
    repeat (4) send_ab(8'hBC);
    send_ab(8'h5A);
    chk("p5.relock", 32'(def_locked), 32'h1);
    repeat (4) ab_bit(1'b1);
    l0 = n_def_ll;
    #2;
    reset = 1'b1;
    #1;
    mdef = mreset(mdef); mgap = mreset(mgap); mlsb = mreset(mlsb);
    chk("p5.rst.data", 32'(def_data), 32'h0);
    chk("p5.rst.valid", 32'(def_valid), 32'h0);
    chk("p5.rst.locked", 32'(def_locked), 32'h0);
    chk("p5.rst.comma", 32'(def_cd), 32'h0);
    chk("p5.rst.lost", 32'(def_ll), 32'h0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    idle();
    chk("p5.nolostcnt", 32'(n_def_ll - l0), 32'd0);

    // 10-bit LSB-first configuration
    c0 = n_lsb_cd;
    repeat (3) send_c(10'h17C);
    chk("p6.ncomma", 32'(n_lsb_cd - c0), 32'd1);
    v0 = n_lsb_val;
    send_c(10'h2A5);
    chk("p6.valid", 32'(lsb_valid), 32'h1);
    chk("p6.data", 32'(lsb_data), 32'h2A5);
    chk("p6.model", 32'(mlsb.data), 32'h2A5);
    chk("p6.nvalid", 32'(n_lsb_val - v0), 32'd1);
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
